mempool_tile_resp_demux: RTL and testbench

//  Receive-side counterpart of the tile response arbiter. Takes NumInp response

---
 rtl/mempool_tile_resp_demux_pkg.sv | 20 ++
 rtl/fifo_v3.sv | 59 +++++
 rtl/mempool_tile_resp_demux_rr.sv | 79 +++++++
 rtl/mempool_tile_resp_demux.sv | 138 +++++++++++++
 tb/tb_mempool_tile_resp_demux.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mempool_tile_resp_demux_pkg.sv
// Shared definitions for the tile response demultiplexer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package mempool_tile_resp_demux_pkg;

   // Per-output arbiter state: free to pick, or holding a granted input until handshake.
   typedef enum logic {
      RR_IDLE   = 1'b0,
      RR_LOCKED = 1'b1
   } rr_state_e;

   // Width of the per-output conflict-stall counters.
   localparam int unsigned StallCntW = 32;

   // Index width for a set of num_idx items; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned num_idx);
      return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO, DEPTH entries of DATA_WIDTH bits, head shown on data_o.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: full_o is registered state; pushes while full and pops while empty are ignored.
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 2,
   localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AddrW-1:0]      r_rd_ptr;
   logic [AddrW-1:0]      r_wr_ptr;
   logic [CntW-1:0]       r_cnt;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] ptr);
      return (ptr == AddrW'(DEPTH - 1)) ? '0 : ptr + AddrW'(1);
   endfunction

   assign full_o  = (r_cnt == CntW'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CntW'(1);
            2'b01:   r_cnt <= r_cnt - CntW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

endmodule

// File: rtl/mempool_tile_resp_demux_rr.sv
// Locking round-robin arbiter for one output port over all input FIFO heads.
// Latency: grant is combinational from req_i (IDLE) or from the latched index (LOCKED).
// Backpressure: a grant refused by ready_i is locked and held until the handshake completes.
// Ports: clk_i/rst_ni (sync, active low); req_i per-input head request; ready_i output ready;
//        gnt_idx_o granted input; valid_o output valid; pop_o handshake; locked_o lock state.
module mempool_tile_resp_demux_rr
   import mempool_tile_resp_demux_pkg::*;
#(
   parameter int unsigned NumInp = 16,
   localparam int unsigned IdxW  = idx_width(NumInp)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NumInp-1:0] req_i,
   input  logic              ready_i,
   output logic [IdxW-1:0]   gnt_idx_o,
   output logic              valid_o,
   output logic              pop_o,
   output logic              locked_o
);

   rr_state_e        r_state;
   logic [IdxW-1:0]  r_rr_ptr;
   logic [IdxW-1:0]  r_lock_idx;
   logic [IdxW-1:0]  w_pick_idx;
   logic [IdxW-1:0]  w_cand;
   logic [IdxW-1:0]  w_ptr_nxt;
   logic             w_pick_vld;

   // First requester at or after the RR pointer, wrapping past NumInp-1 back to 0.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      w_cand     = '0;
      for (int unsigned k = 0; k < NumInp; k++) begin
         w_cand = IdxW'((32'(r_rr_ptr) + k) % NumInp);
         if (!w_pick_vld && req_i[w_cand]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_cand;
         end
      end
   end

   assign locked_o  = (r_state == RR_LOCKED);
   assign gnt_idx_o = locked_o ? r_lock_idx : w_pick_idx;
   // A locked input cannot lose its head: only this output pops it and its dest is in range.
   assign valid_o   = locked_o | w_pick_vld;
   assign pop_o     = valid_o & ready_i;
   assign w_ptr_nxt = IdxW'((32'(gnt_idx_o) + 32'd1) % NumInp);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= RR_IDLE;
         r_rr_ptr   <= '0;
         r_lock_idx <= '0;
      end else begin
         case (r_state)
            RR_IDLE: begin
               if (w_pick_vld) begin
                  if (ready_i) begin
                     r_rr_ptr <= w_ptr_nxt;
                  end else begin
                     r_lock_idx <= w_pick_idx;
                     r_state    <= RR_LOCKED;
                  end
               end
            end
            RR_LOCKED: begin
               if (ready_i) begin
                  r_rr_ptr <= w_ptr_nxt;
                  r_state  <= RR_IDLE;
               end
            end
            default: r_state <= RR_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mempool_tile_resp_demux.sv
// Routes NumInp buffered response streams to NumOut core ports by a per-entry destination index.
// Latency: 1 cycle minimum from input push to output valid; 1 beat/cycle/input without conflicts.
// Backpressure: ready_o is the registered not-full flag of each input FIFO; outputs lock until taken.
// Ports: clk_i/rst_ni sync active-low reset; data_i/dest_i/valid_i/ready_o per-input stream;
//        data_o/valid_o/ready_i per-output stream; drop_o pulses when an out-of-range head is discarded;
//        stall_cnt_o per-output conflict-stall counters, live only with MEMPOOL_TILE_RESP_DEMUX_STATS_EN.
module mempool_tile_resp_demux
   import mempool_tile_resp_demux_pkg::*;
#(
   parameter int unsigned  NumInp    = 16,
   parameter int unsigned  NumOut    = 4,
   parameter int unsigned  BufDepth  = 2,
   parameter type          payload_t = logic,
   localparam int unsigned DestW     = idx_width(NumOut)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  payload_t [NumInp-1:0]             data_i,
   input  logic [NumInp-1:0][DestW-1:0]      dest_i,
   input  logic [NumInp-1:0]                 valid_i,
   output logic [NumInp-1:0]                 ready_o,
   output payload_t [NumOut-1:0]             data_o,
   output logic [NumOut-1:0]                 valid_o,
   input  logic [NumOut-1:0]                 ready_i,
   output logic [NumInp-1:0]                 drop_o,
   output logic [NumOut-1:0][StallCntW-1:0]  stall_cnt_o
);

   localparam int unsigned  PayW = $bits(payload_t);
   localparam int unsigned  EntW = PayW + DestW;
   localparam int unsigned  IdxW = idx_width(NumInp);
   // NumOut widened by one bit so the range check also works when NumOut is a power of two.
   localparam logic [DestW:0] NumOutExt = (DestW + 1)'(NumOut);

   logic [NumInp-1:0]                w_full;
   logic [NumInp-1:0]                w_empty;
   logic [NumInp-1:0]                w_push;
   logic [NumInp-1:0]                w_pop;
   logic [NumInp-1:0]                w_drop;
   logic [NumInp-1:0][EntW-1:0]      w_wdata;
   logic [NumInp-1:0][EntW-1:0]      w_rdata;
   payload_t [NumInp-1:0]            w_head_dat;
   logic [NumInp-1:0][DestW-1:0]     w_head_dest;
   logic [NumOut-1:0][NumInp-1:0]    w_req;
   logic [NumOut-1:0][IdxW-1:0]      w_gnt_idx;
   logic [NumOut-1:0]                w_rr_vld;
   logic [NumOut-1:0]                w_rr_pop;
   logic [NumOut-1:0]                w_rr_locked;
   logic                             w_unused_locked;

   // Input buffering: destination and payload travel together through one FIFO.
   for (genvar i = 0; i < NumInp; i++) begin : g_inp
      assign w_wdata[i]     = {dest_i[i], data_i[i]};
      assign w_push[i]      = valid_i[i] & ~w_full[i];
      assign w_head_dest[i] = w_rdata[i][EntW-1 -: DestW];
      assign w_head_dat[i]  = w_rdata[i][PayW-1:0];
      assign w_drop[i]      = ~w_empty[i] & ({1'b0, w_head_dest[i]} >= NumOutExt);

      fifo_v3 #(
         .DATA_WIDTH (EntW),
         .DEPTH      (BufDepth)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .flush_i (1'b0),
         .full_o  (w_full[i]),
         .empty_o (w_empty[i]),
         .data_i  (w_wdata[i]),
         .push_i  (w_push[i]),
         .data_o  (w_rdata[i]),
         .pop_i   (w_pop[i])
      );
   end

   assign ready_o = ~w_full;
   assign drop_o  = w_drop;

   always_comb begin
      w_req = '0;
      for (int j = 0; j < NumOut; j++) begin
         for (int i = 0; i < NumInp; i++) begin
            w_req[j][i] = ~w_empty[i] & (w_head_dest[i] == DestW'(j));
         end
      end
   end

   // Each head targets a single output, so at most one source pops a given FIFO per cycle.
   always_comb begin
      w_pop = w_drop;
      for (int j = 0; j < NumOut; j++) begin
         if (w_rr_pop[j]) w_pop[w_gnt_idx[j]] = 1'b1;
      end
   end

   for (genvar j = 0; j < NumOut; j++) begin : g_out
      mempool_tile_resp_demux_rr #(
         .NumInp (NumInp)
      ) u_rr (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .req_i     (w_req[j]),
         .ready_i   (ready_i[j]),
         .gnt_idx_o (w_gnt_idx[j]),
         .valid_o   (w_rr_vld[j]),
         .pop_o     (w_rr_pop[j]),
         .locked_o  (w_rr_locked[j])
      );

      assign valid_o[j] = w_rr_vld[j];
      assign data_o[j]  = w_head_dat[w_gnt_idx[j]];
   end

   // Lock state is exported by the arbiter for observation only.
   assign w_unused_locked = ^w_rr_locked;

`ifdef MEMPOOL_TILE_RESP_DEMUX_STATS_EN
   for (genvar j = 0; j < NumOut; j++) begin : g_stats
      logic                 w_stall;
      logic [StallCntW-1:0] r_stall_cnt;

      // Stall: several heads compete for this output, or the presented beat is refused.
      assign w_stall = ((w_req[j] & (w_req[j] - NumInp'(1))) != '0) | (w_rr_vld[j] & ~ready_i[j]);

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            r_stall_cnt <= '0;
         end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + StallCntW'(1);
         end
      end

      assign stall_cnt_o[j] = r_stall_cnt;
   end
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mempool_tile_resp_demux.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
// NumOut=5 gives a 3-bit destination, so indices 5..7 exercise the out-of-range drop path.
module tb_mempool_tile_resp_demux;

   localparam int unsigned NumInp   = 16;
   localparam int unsigned NumOut   = 5;
   localparam int unsigned BufDepth = 2;
   localparam int unsigned DestW    = 3;
   localparam int unsigned DatW     = 8;
`ifdef MEMPOOL_TILE_RESP_DEMUX_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic                           clk_i = 1'b0;
   logic                           rst_ni;
   logic [NumInp-1:0][DatW-1:0]    data_i;
   logic [NumInp-1:0][DestW-1:0]   dest_i;
   logic [NumInp-1:0]              valid_i;
   logic [NumInp-1:0]              ready_o;
   logic [NumOut-1:0][DatW-1:0]    data_o;
   logic [NumOut-1:0]              valid_o;
   logic [NumOut-1:0]              ready_i;
   logic [NumInp-1:0]              drop_o;
   logic [NumOut-1:0][31:0]        stall_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: per-input queues of (payload, dest), per-output pointer/lock/counter.
   logic [DatW-1:0]  m_dat [NumInp][$];
   int unsigned      m_dst [NumInp][$];
   int               m_lock [NumOut];
   int unsigned      m_ptr  [NumOut];
   longint unsigned  m_cnt  [NumOut];

   always #5 clk_i = ~clk_i;

   mempool_tile_resp_demux #(
      .NumInp    (NumInp),
      .NumOut    (NumOut),
      .BufDepth  (BufDepth),
      .payload_t (logic [DatW-1:0])
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .data_i      (data_i),
      .dest_i      (dest_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .drop_o      (drop_o),
      .stall_cnt_o (stall_cnt_o)
   );

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      valid_i = '0;
      dest_i  = '0;
      data_i  = '0;
      ready_i = '1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst_ni = 1'b1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NumInp; i++) begin
         m_dat[i].delete();
         m_dst[i].delete();
      end
      for (int j = 0; j < NumOut; j++) begin
         m_lock[j] = -1;
         m_ptr[j]  = 0;
         m_cnt[j]  = 0;
      end
   endtask

   task automatic test_reset();
      rst_ni  = 1'b0;
      idle_inputs();
      valid_i = '1;
      next_cycle();
      next_cycle();
      rst_ni  = 1'b1;
      valid_i = '0;
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      n_checks++;
      if (ready_o !== '1) begin n_errors++; $display("FAIL reset_ready: got %h want ffff", ready_o); end
      n_checks++;
      if (drop_o !== '0) begin n_errors++; $display("FAIL reset_drop: got %h want 0", drop_o); end
      n_checks++;
      if (stall_cnt_o !== '0) begin n_errors++; $display("FAIL reset_stall: got %h want 0", stall_cnt_o); end
      next_cycle();
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL reset_push_discard: got %b want 0", valid_o); end
   endtask

   task automatic test_single();
      do_reset();
      valid_i[3] = 1'b1; dest_i[3] = 3'd1; data_i[3] = 8'hA5;
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL single_early: got %b want 0", valid_o); end
      next_cycle();
      valid_i = '0;
      #4;
      n_checks++;
      if (valid_o !== 5'b00010) begin n_errors++; $display("FAIL single_valid: got %b want 00010", valid_o); end
      n_checks++;
      if (data_o[1] !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %h want a5", data_o[1]); end
      next_cycle();
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL single_after: got %b want 0", valid_o); end
   endtask

   task automatic test_rr_order();
      logic [DatW-1:0] exp_dat [3];
      exp_dat = '{8'h10, 8'h15, 8'h19};
      do_reset();
      valid_i[0] = 1'b1; dest_i[0] = 3'd2; data_i[0] = 8'h10;
      valid_i[5] = 1'b1; dest_i[5] = 3'd2; data_i[5] = 8'h15;
      valid_i[9] = 1'b1; dest_i[9] = 3'd2; data_i[9] = 8'h19;
      next_cycle();
      valid_i = '0;
      for (int k = 0; k < 3; k++) begin
         #4;
         n_checks++;
         if (valid_o !== 5'b00100 || data_o[2] !== exp_dat[k]) begin
            n_errors++;
            $display("FAIL rr_order beat%0d: got v=%b d=%h want v=00100 d=%h", k, valid_o, data_o[2], exp_dat[k]);
         end
         next_cycle();
      end
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL rr_drain: got %b want 0", valid_o); end
      n_checks++;
      if (stall_cnt_o[2] !== (StatsEn ? 32'd2 : 32'd0)) begin
         n_errors++; $display("FAIL rr_stall_cnt: got %0d want %0d", stall_cnt_o[2], StatsEn ? 2 : 0);
      end
   endtask

   task automatic test_lock_hold();
      do_reset();
      ready_i[0] = 1'b0;
      valid_i[4] = 1'b1; dest_i[4] = 3'd0; data_i[4] = 8'h44;
      next_cycle();
      valid_i[4] = 1'b0;
      valid_i[1] = 1'b1; dest_i[1] = 3'd0; data_i[1] = 8'h11;
      for (int k = 0; k < 5; k++) begin
         #4;
         n_checks++;
         if (valid_o[0] !== 1'b1 || data_o[0] !== 8'h44) begin
            n_errors++; $display("FAIL lock_hold cyc%0d: got v=%b d=%h want v=1 d=44", k, valid_o[0], data_o[0]);
         end
         next_cycle();
         valid_i = '0;
      end
      ready_i[0] = 1'b1;
      #4;
      n_checks++;
      if (valid_o[0] !== 1'b1 || data_o[0] !== 8'h44) begin
         n_errors++; $display("FAIL lock_release: got v=%b d=%h want v=1 d=44", valid_o[0], data_o[0]);
      end
      next_cycle();
      #4;
      n_checks++;
      if (valid_o[0] !== 1'b1 || data_o[0] !== 8'h11) begin
         n_errors++; $display("FAIL lock_next: got v=%b d=%h want v=1 d=11", valid_o[0], data_o[0]);
      end
      next_cycle();
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL lock_drain: got %b want 0", valid_o); end
      n_checks++;
      if (stall_cnt_o[0] !== (StatsEn ? 32'd6 : 32'd0)) begin
         n_errors++; $display("FAIL lock_stall_cnt: got %0d want %0d", stall_cnt_o[0], StatsEn ? 6 : 0);
      end
   endtask

   task automatic test_fifo_full();
      logic [NumInp-1:0] exp_rdy [5];
      logic [DatW-1:0]   exp_dat [5];
      logic [NumOut-1:0] exp_vld [5];
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      exp_vld = '{5'b00000, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
      exp_dat = '{8'h00, 8'h70, 8'h70, 8'h70, 8'h71};
      do_reset();
      ready_i[3] = 1'b0;
      valid_i[7] = 1'b1; dest_i[7] = 3'd3; data_i[7] = 8'h70;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) data_i[7] = 8'h71;
         if (k == 2) data_i[7] = 8'h72;
         if (k == 3) ready_i[3] = 1'b1;
         #4;
         n_checks++;
         if (ready_o[7] !== exp_rdy[k][0] || valid_o !== exp_vld[k] || (exp_vld[k][3] && data_o[3] !== exp_dat[k])) begin
            n_errors++;
            $display("FAIL full_cyc%0d: got rdy=%b v=%b d=%h want rdy=%b v=%b d=%h", k,
                     ready_o[7], valid_o, data_o[3], exp_rdy[k][0], exp_vld[k], exp_dat[k]);
         end
         next_cycle();
      end
      valid_i = '0;
      #4;
      n_checks++;
      if (valid_o !== 5'b01000 || data_o[3] !== 8'h72) begin
         n_errors++; $display("FAIL full_beat2: got v=%b d=%h want v=01000 d=72", valid_o, data_o[3]);
      end
      next_cycle();
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL full_drain: got %b want 0", valid_o); end
   endtask

   task automatic test_drop();
      do_reset();
      valid_i[2] = 1'b1; dest_i[2] = 3'(NumOut); data_i[2] = 8'h55;
      next_cycle();
      dest_i[2] = 3'd0; data_i[2] = 8'h20;
      #4;
      n_checks++;
      if (drop_o !== 16'h0004 || valid_o !== '0) begin
         n_errors++; $display("FAIL drop_pulse: got drop=%h v=%b want drop=0004 v=0", drop_o, valid_o);
      end
      next_cycle();
      valid_i = '0;
      #4;
      n_checks++;
      if (drop_o !== '0 || valid_o !== 5'b00001 || data_o[0] !== 8'h20) begin
         n_errors++; $display("FAIL drop_next: got drop=%h v=%b d=%h want drop=0 v=00001 d=20", drop_o, valid_o, data_o[0]);
      end
   endtask

   task automatic test_reset_locked();
      do_reset();
      ready_i[1] = 1'b0;
      valid_i[3] = 1'b1; dest_i[3] = 3'd1; data_i[3] = 8'h33;
      valid_i[6] = 1'b1; dest_i[6] = 3'd1; data_i[6] = 8'h66;
      next_cycle();
      valid_i = '0;
      #4;
      n_checks++;
      if (valid_o[1] !== 1'b1 || data_o[1] !== 8'h33) begin
         n_errors++; $display("FAIL rstlock_pre: got v=%b d=%h want v=1 d=33", valid_o[1], data_o[1]);
      end
      next_cycle();
      rst_ni = 1'b0;
      valid_i[0] = 1'b1; dest_i[0] = 3'd1; data_i[0] = 8'h99;
      next_cycle();
      rst_ni = 1'b1;
      idle_inputs();
      #4;
      n_checks++;
      if (valid_o !== '0 || ready_o !== '1 || stall_cnt_o !== '0 || drop_o !== '0) begin
         n_errors++; $display("FAIL rstlock_post: got v=%b rdy=%h stall=%h drop=%h want all idle",
                              valid_o, ready_o, stall_cnt_o, drop_o);
      end
      next_cycle();
      #4;
      n_checks++;
      if (valid_o !== '0) begin n_errors++; $display("FAIL rstlock_lost: got %b want 0", valid_o); end
   endtask

   task automatic test_random(input int n_cyc);
      logic [NumInp-1:0] e_rdy;
      logic [NumInp-1:0] e_drop;
      logic [NumOut-1:0] e_vld;
      logic [NumOut-1:0] e_stall;
      logic [DatW-1:0]   e_dat [NumOut];
      logic [DatW-1:0]   dummy_d;
      int unsigned       dummy_t;
      int                sel [NumOut];
      int                nreq;
      int                c;
      int unsigned       load;
      do_reset();
      model_clear();
      load = 50;
      for (int cyc = 0; cyc < n_cyc; cyc++) begin
         if (cyc % 100 == 0) load = $urandom_range(10, 95);
         rst_ni = ($urandom_range(0, 399) != 0);
         for (int i = 0; i < NumInp; i++) begin
            valid_i[i] = ($urandom_range(0, 99) < load);
            dest_i[i]  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(NumOut, 7)) : 3'($urandom_range(0, NumOut - 1));
            data_i[i]  = 8'($urandom);
         end
         for (int j = 0; j < NumOut; j++) ready_i[j] = ($urandom_range(0, 99) < 65);

         // Expected outputs from the queued contents and per-output arbitration state.
         for (int i = 0; i < NumInp; i++) begin
            e_rdy[i]  = (m_dat[i].size() < BufDepth);
            e_drop[i] = (m_dat[i].size() > 0) && (m_dst[i][0] >= NumOut);
         end
         for (int j = 0; j < NumOut; j++) begin
            nreq = 0;
            sel[j] = m_lock[j];
            for (int k = 0; k < NumInp; k++) begin
               c = int'((m_ptr[j] + k) % NumInp);
               if (m_dat[c].size() > 0 && m_dst[c][0] == j) begin
                  nreq++;
                  if (sel[j] < 0) sel[j] = c;
               end
            end
            e_vld[j]   = (sel[j] >= 0);
            e_dat[j]   = e_vld[j] ? m_dat[sel[j]][0] : '0;
            e_stall[j] = (nreq > 1) || (e_vld[j] && !ready_i[j]);
         end

         #4;
         n_checks++;
         if (ready_o !== e_rdy) begin n_errors++; $display("FAIL rand_ready cyc%0d: got %h want %h", cyc, ready_o, e_rdy); end
         n_checks++;
         if (valid_o !== e_vld) begin n_errors++; $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, valid_o, e_vld); end
         n_checks++;
         if (drop_o !== e_drop) begin n_errors++; $display("FAIL rand_drop cyc%0d: got %h want %h", cyc, drop_o, e_drop); end
         for (int j = 0; j < NumOut; j++) begin
            if (e_vld[j]) begin
               n_checks++;
               if (data_o[j] !== e_dat[j]) begin
                  n_errors++; $display("FAIL rand_data cyc%0d out%0d: got %h want %h", cyc, j, data_o[j], e_dat[j]);
               end
            end
            n_checks++;
            if (stall_cnt_o[j] !== 32'(m_cnt[j])) begin
               n_errors++; $display("FAIL rand_stall cyc%0d out%0d: got %0d want %0d", cyc, j, stall_cnt_o[j], m_cnt[j]);
            end
         end

         // Advance the model across the coming clock edge.
         if (!rst_ni) begin
            model_clear();
         end else begin
            for (int j = 0; j < NumOut; j++) begin
               if (sel[j] >= 0) begin
                  if (ready_i[j]) begin
                     dummy_d = m_dat[sel[j]].pop_front();
                     dummy_t = m_dst[sel[j]].pop_front();
                     m_ptr[j]  = (sel[j] + 1) % NumInp;
                     m_lock[j] = -1;
                  end else begin
                     m_lock[j] = sel[j];
                  end
               end
               if (StatsEn && e_stall[j] && m_cnt[j] < 64'hFFFF_FFFF) m_cnt[j]++;
            end
            for (int i = 0; i < NumInp; i++) begin
               if (e_drop[i]) begin
                  dummy_d = m_dat[i].pop_front();
                  dummy_t = m_dst[i].pop_front();
               end
               if (valid_i[i] && e_rdy[i]) begin
                  m_dat[i].push_back(data_i[i]);
                  m_dst[i].push_back(int'(dest_i[i]));
               end
            end
         end
         next_cycle();
      end
      rst_ni = 1'b1;
      idle_inputs();
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not complete within bound");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_rr_order();
      test_lock_hold();
      test_fifo_full();
      test_drop();
      test_reset_locked();
      test_random(2500);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
